// File: rtl/shared_expr_pipe.sv
// Two-stage expression pipeline: stage 1 registers shared sub-terms once,
// stage 2 combines them into six results behind a valid/ready handshake.
module shared_expr_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output1,
    output logic [WIDTH-1:0] output2,
    output logic [WIDTH-1:0] output3,
    output logic [WIDTH-1:0] output4,
    output logic [WIDTH-1:0] output5,
    output logic [WIDTH-1:0] output6,
    output logic [CNT_W-1:0] txn_count
);

    function automatic logic [WIDTH-1:0] mul_trunc(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return a * b;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] xy_p1, pz_p1, qr_p1, sxy_p1, px_p1, st_p1;
    logic [WIDTH-1:0] q_p1, r_p1, p_p1;
    logic             s1_adv, s2_adv;

    // Only out_ready reaches in_ready combinationally; everything else is state.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: shared sub-terms
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            xy_p1  <= mul_trunc(X, Y);
            pz_p1  <= P + Z;
            qr_p1  <= Q - R;
            sxy_p1 <= X + Y;
            px_p1  <= P + X;
            st_p1  <= S + T;
            q_p1   <= Q;
            r_p1   <= R;
            p_p1   <= P;
        end
    end

    // Stage 2: results, handshake state and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            txn_count <= '0;
            output1   <= '0;
            output2   <= '0;
            output3   <= '0;
            output4   <= '0;
            output5   <= '0;
            output6   <= '0;
        end else begin
            if (s1_adv) begin
                vld_p1 <= in_valid;
            end
            if (s2_adv) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    output1 <= xy_p1 + pz_p1;
                    output2 <= mul_trunc(pz_p1, qr_p1);
                    output3 <= sxy_p1 + st_p1;
                    output4 <= mul_trunc(xy_p1 + q_p1, px_p1);
                    output5 <= (xy_p1 + p_p1) - (r_p1 + px_p1);
                    output6 <= mul_trunc(sxy_p1 + p_p1, qr_p1);
                end
            end
            if (out_valid && out_ready) begin
                txn_count <= txn_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shared_expr_pipe.sv
// Scoreboard bench for shared_expr_pipe at WIDTH 32 (CNT_W 4), 8 and 64.
module tb_shared_expr_pipe;

    typedef logic [5:0][63:0] res_t;
    typedef logic [7:0][63:0] ops_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] vin;
    logic       rdy32;
    ops_t       ops;

    logic        in_ready32, out_valid32;
    logic [31:0] o32_1, o32_2, o32_3, o32_4, o32_5, o32_6;
    logic [3:0]  txn32;
    logic        in_ready8, out_valid8;
    logic [7:0]  o8_1, o8_2, o8_3, o8_4, o8_5, o8_6;
    logic [15:0] txn8;
    logic        in_ready64, out_valid64;
    logic [63:0] o64_1, o64_2, o64_3, o64_4, o64_5, o64_6;
    logic [15:0] txn64;

    res_t act32, act8, act64;
    assign act32 = {64'(o32_6), 64'(o32_5), 64'(o32_4), 64'(o32_3), 64'(o32_2), 64'(o32_1)};
    assign act8  = {64'(o8_6), 64'(o8_5), 64'(o8_4), 64'(o8_3), 64'(o8_2), 64'(o8_1)};
    assign act64 = {o64_6, o64_5, o64_4, o64_3, o64_2, o64_1};

    shared_expr_pipe #(.WIDTH(32), .CNT_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(in_ready32),
        .X(ops[0][31:0]), .Y(ops[1][31:0]), .Z(ops[2][31:0]), .P(ops[3][31:0]),
        .Q(ops[4][31:0]), .R(ops[5][31:0]), .S(ops[6][31:0]), .T(ops[7][31:0]),
        .out_valid(out_valid32), .out_ready(rdy32),
        .output1(o32_1), .output2(o32_2), .output3(o32_3),
        .output4(o32_4), .output5(o32_5), .output6(o32_6), .txn_count(txn32)
    );

    shared_expr_pipe #(.WIDTH(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(in_ready8),
        .X(ops[0][7:0]), .Y(ops[1][7:0]), .Z(ops[2][7:0]), .P(ops[3][7:0]),
        .Q(ops[4][7:0]), .R(ops[5][7:0]), .S(ops[6][7:0]), .T(ops[7][7:0]),
        .out_valid(out_valid8), .out_ready(1'b1),
        .output1(o8_1), .output2(o8_2), .output3(o8_3),
        .output4(o8_4), .output5(o8_5), .output6(o8_6), .txn_count(txn8)
    );

    shared_expr_pipe #(.WIDTH(64), .CNT_W(16)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(in_ready64),
        .X(ops[0]), .Y(ops[1]), .Z(ops[2]), .P(ops[3]),
        .Q(ops[4]), .R(ops[5]), .S(ops[6]), .T(ops[7]),
        .out_valid(out_valid64), .out_ready(1'b1),
        .output1(o64_1), .output2(o64_2), .output3(o64_3),
        .output4(o64_4), .output5(o64_5), .output6(o64_6), .txn_count(txn64)
    );

    res_t q0[$], q1[$], q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic ops_t mkops(input logic [63:0] x, y, z, p, q, r, s, t);
        return {t, s, r, q, p, z, y, x};
    endfunction

    function automatic res_t mkres(input logic [63:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    function automatic ops_t rnd_ops();
        ops_t o;
        for (int i = 0; i < 8; i++) o[i] = {$urandom(), $urandom()};
        return o;
    endfunction

    // Reference equations evaluated directly on the raw operands, mod 2^w.
    function automatic res_t model(input int w, input ops_t o);
        logic [63:0] m, x, y, z, p, q, r, s, t;
        res_t res;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x = o[0] & m; y = o[1] & m; z = o[2] & m; p = o[3] & m;
        q = o[4] & m; r = o[5] & m; s = o[6] & m; t = o[7] & m;
        res[0] = (x * y + (z + p)) & m;
        res[1] = ((p + z) * (q - r)) & m;
        res[2] = (x + y + s + t) & m;
        res[3] = ((x * y + q) * (p + x)) & m;
        res[4] = ((x * y + p) - (r + p + x)) & m;
        res[5] = ((x + y + p) * (q - r)) & m;
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int sel, input res_t act);
        res_t e;
        int   sz;
        sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_unexpected_out: got output1=0x%0h, expected no result", sel, act[0]);
            return;
        end
        case (sel)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        for (int i = 0; i < 6; i++) chk($sformatf("dut%0d_output%0d", sel, i + 1), act[i], e[i]);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid32 && rdy32) check_out(0, act32);
            if (out_valid8) check_out(1, act8);
            if (out_valid64) check_out(2, act64);
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int sel, input ops_t o, input res_t exp);
        logic rdy, done;
        done = 1'b0;
        ops = o;
        vin[sel] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = (sel == 0) ? in_ready32 : (sel == 1) ? in_ready8 : in_ready64;
            if (rdy) begin
                done = 1'b1;
                case (sel)
                    0:       q0.push_back(exp);
                    1:       q1.push_back(exp);
                    default: q2.push_back(exp);
                endcase
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        vin[sel] = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout dut%0d: got no in_ready, expected acceptance", sel);
        end
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending, expected 0", q0.size(), q1.size(), q2.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        ops_t o, oa;
        int   run;
        rst = 1'b1; vin = '0; rdy32 = 1'b1; ops = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid32), 0);
        chk("rst_txn", 64'(txn32), 0);
        chk("rst_in_ready", 64'(in_ready32), 1);
        chk("rst_output1", 64'(o32_1), 0);
        chk("rst_output5", 64'(o32_5), 0);

        oa = mkops(2, 3, 4, 5, 10, 7, 1, 1);
        send(0, oa, mkres(15, 27, 7, 112, 64'hFFFF_FFFD, 30));
        drain();
        chk("txn_after_basic", 64'(txn32), 1);
        send(0, mkops(64'hFFFF_FFFF, 2, 0, 0, 0, 0, 0, 0),
             mkres(64'hFFFF_FFFE, 0, 1, 2, 64'hFFFF_FFFF, 0));
        drain();
        chk("txn_after_wrap", 64'(txn32), 2);

        // Back-to-back stream: results must appear on consecutive cycles.
        fork
            for (int k = 0; k < 8; k++) begin
                o = mkops(k + 1, k + 2, 3 * k, k, 100 - k, 2 * k, k, 7);
                send(0, o, model(32, o));
            end
            begin
                run = 0;
                for (int k = 0; k < 10 && !out_valid32; k++) @(negedge clk);
                while (out_valid32 && run < 20) begin
                    run++;
                    @(negedge clk);
                end
                chk("stream_consecutive", 64'(run), 8);
            end
        join
        drain();
        chk("txn_after_stream", 64'(txn32), 10);

        // Stall: two sets fill the pipe, third waits until release.
        rdy32 = 1'b0;
        send(0, oa, mkres(15, 27, 7, 112, 64'hFFFF_FFFD, 30));
        o = rnd_ops();
        send(0, o, model(32, o));
        fork
            begin
                ops_t oc;
                oc = rnd_ops();
                send(0, oc, model(32, oc));
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready32), 0);
                    chk("stall_out_valid", 64'(out_valid32), 1);
                    chk("stall_hold_output1", 64'(o32_1), 15);
                end
                @(posedge clk);
                #1 rdy32 = 1'b1;
            end
        join
        drain();
        chk("txn_after_stall", 64'(txn32), 13);

        // Reset with two sets in flight and in_valid asserted during reset.
        rdy32 = 1'b0;
        o = rnd_ops();
        send(0, o, model(32, o));
        o = rnd_ops();
        send(0, o, model(32, o));
        rst = 1'b1;
        vin[0] = 1'b1;
        ops = rnd_ops();
        q0.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid32), 0);
        chk("midrst_txn", 64'(txn32), 0);
        rst = 1'b0;
        vin[0] = 1'b0;
        rdy32 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(out_valid32), 0);

        for (int k = 0; k < 17; k++) begin
            o = rnd_ops();
            send(0, o, model(32, o));
        end
        drain();
        chk("txn_wrap_17", 64'(txn32), 1);

        send(1, oa, mkres(15, 27, 7, 112, 8'hFD, 30));
        send(2, oa, mkres(15, 27, 7, 112, 64'hFFFF_FFFF_FFFF_FFFD, 30));
        send(2, mkops(64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 0, 0, 0, 0),
             mkres(64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0));
        for (int k = 0; k < 6; k++) begin
            o = rnd_ops();
            send(1, o, model(8, o));
            o = rnd_ops();
            send(2, o, model(64, o));
        end
        drain();
        chk("txn8_count", 64'(txn8), 7);
        chk("txn64_count", 64'(txn64), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
